// File: rtl/dm_write_arbiter_if.sv
// Signal bundle for dm_write_arbiter: four core write ports merged onto one shared data-memory port.
// Cores drive through master; the arbiter side sees slave.
interface dm_write_arbiter_if;
  logic [3:0]  wr_en;
  logic [63:0] addr;
  logic [63:0] data;
  logic [3:0]  end_p;
  logic [3:0]  status;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [3:0]  grant;
  logic [3:0]  ovf;
  logic [15:0] wr_cnt;
  logic        all_done;

  modport master (
    output wr_en, addr, data, end_p,
    input  status, mem_we, mem_addr, mem_wdata, grant, ovf, wr_cnt, all_done
  );

  modport slave (
    input  wr_en, addr, data, end_p,
    output status, mem_we, mem_addr, mem_wdata, grant, ovf, wr_cnt, all_done
  );
endinterface

// File: rtl/dm_write_arbiter.sv
// Merges four per-core data-memory writes into one registered memory write port, one write per cycle.
// Define DM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (core 0 highest).
module dm_write_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  wr_en_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] data_i,
  input  logic [3:0]  end_i,
  output logic [3:0]  status_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic [3:0]  grant_o,
  output logic [3:0]  ovf_o,
  output logic [15:0] wr_cnt_o,
  output logic        all_done_o
);

  logic [3:0]  slot_valid_q, slot_valid_d;
  logic [15:0] slot_addr_q [4];
  logic [15:0] slot_addr_d [4];
  logic [15:0] slot_data_q [4];
  logic [15:0] slot_data_d [4];
  logic [3:0]  ovf_q, ovf_d;

  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [3:0]  grant_q;
  logic [15:0] wr_cnt_q;
  logic        all_done_q;

  logic        sel_any;
  logic [1:0]  sel_idx;
  logic [1:0]  cand;
  logic [3:0]  sel_oh;

`ifdef DM_ARB_RR_EN
  logic [1:0]  rr_ptr_q;
`endif

  assign status_o    = ~slot_valid_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign grant_o     = grant_q;
  assign ovf_o       = ovf_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign all_done_o  = all_done_q;

  // Pick one valid slot; in round-robin mode the scan starts just after the last winner.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = 2'd0;
    cand    = 2'd0;
    for (int i = 0; i < 4; i++) begin
`ifdef DM_ARB_RR_EN
      cand = rr_ptr_q + 2'd1 + 2'(i);
`else
      cand = 2'(i);
`endif
      if (!sel_any && slot_valid_q[cand]) begin
        sel_any = 1'b1;
        sel_idx = cand;
      end
    end
    sel_oh = sel_any ? (4'b0001 << sel_idx) : 4'b0000;
  end

  // A slot accepts a new request when empty or when it is being drained this cycle.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    ovf_d        = ovf_q;
    for (int k = 0; k < 4; k++) begin
      if (wr_en_i[k] && (!slot_valid_q[k] || sel_oh[k])) begin
        slot_valid_d[k] = 1'b1;
        slot_addr_d[k]  = addr_i[16*k +: 16];
        slot_data_d[k]  = data_i[16*k +: 16];
      end else if (sel_oh[k]) begin
        slot_valid_d[k] = 1'b0;
      end else if (wr_en_i[k]) begin
        ovf_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        slot_addr_q[k] <= 16'h0000;
        slot_data_q[k] <= 16'h0000;
      end
      ovf_q       <= 4'b0000;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      grant_q     <= 4'b0000;
      wr_cnt_q    <= 16'h0000;
      all_done_q  <= 1'b0;
`ifdef DM_ARB_RR_EN
      rr_ptr_q    <= 2'd3;
`endif
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      ovf_q        <= ovf_d;
      mem_we_q     <= sel_any;
      grant_q      <= sel_oh;
      if (sel_any) begin
        mem_addr_q  <= slot_addr_q[sel_idx];
        mem_wdata_q <= slot_data_q[sel_idx];
        if (wr_cnt_q != 16'hFFFF) begin
          wr_cnt_q <= wr_cnt_q + 16'd1;
        end
`ifdef DM_ARB_RR_EN
        rr_ptr_q <= sel_idx;
`endif
      end
      all_done_q <= (&end_i) & ~(|slot_valid_q) & ~mem_we_q;
    end
  end

endmodule
